irq_encoder: RTL

IRQ_ENCODER -- requirements
Module: irq_encoder

---
 rtl/irq_encoder.sv | 60 ++++++
 1 files changed

// File: rtl/irq_encoder.sv
// irq_encoder: sticky interrupt pending register with lowest-index presentation
// through a valid/ready handshake; inverse of the one-hot decoder.
module irq_encoder #(
   parameter int BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [2**BITS-1:0]   req,
   input  logic [2**BITS-1:0]   mask,
   output logic [BITS-1:0]      out_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2**BITS-1:0]   pending,
   output logic                 overflow
);
   localparam int N = 2**BITS;
   typedef enum logic {IDLE, PRESENT} state_t;
   state_t          r_state, w_state_nxt;
   logic [BITS-1:0] r_idx, w_idx_nxt, w_low;
   logic [N-1:0]    r_pending, w_pending_nxt, w_elig, w_clear;
   logic            r_overflow, w_any, w_accept;
   always_comb begin
      w_elig = r_pending & ~mask;
      w_low  = '0;
      // Scan downward so the lowest-numbered eligible source wins.
      for (int i = N - 1; i >= 0; i--)
         if (w_elig[i]) w_low = BITS'(i);
      w_any = |w_elig;
   end
   always_comb begin
      w_accept      = (r_state == PRESENT) && out_ready;
      w_clear       = w_accept ? (N'(1) << r_idx) : '0;
      w_pending_nxt = (r_pending & ~w_clear) | req;
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      if (r_state == IDLE) begin
         w_state_nxt = w_any ? PRESENT : IDLE;
         w_idx_nxt   = w_any ? w_low : r_idx;
      end else begin
         w_state_nxt = w_accept ? IDLE : PRESENT;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_pending  <= w_pending_nxt;
         r_overflow <= r_overflow | (|(req & r_pending & ~w_clear));
      end
   end
   assign out_idx   = r_idx;
   assign out_valid = (r_state == PRESENT);
   assign pending   = r_pending;
   assign overflow  = r_overflow;
endmodule
